// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if
// Bundles the two requester ports, the ROM read path and the busy flag of
// rom_port_arbiter.
//   slave  : arbiter side (takes requests and ROM data, returns grants/responses)
//   master : environment side (requesters plus the ROM itself)
// Signals:
//   i_req0/1, i_addr0/1   request and byte address, port 0 = fetch, port 1 = data
//   o_gnt0/1              combinational grant
//   o_rvalid0/1           one-cycle response pulse
//   o_rdata0/1, o_err0/1  response data and error flag
//   o_rom_addr            word index to ROM (registered)
//   i_rom_data            combinational ROM output for o_rom_addr
//   o_busy                high while an access is in flight
interface rom_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  i_req0;
   logic                  i_req1;
   logic [ADDR_WIDTH-1:0] i_addr0;
   logic [ADDR_WIDTH-1:0] i_addr1;
   logic                  o_gnt0;
   logic                  o_gnt1;
   logic                  o_rvalid0;
   logic                  o_rvalid1;
   logic [DATA_WIDTH-1:0] o_rdata0;
   logic [DATA_WIDTH-1:0] o_rdata1;
   logic                  o_err0;
   logic                  o_err1;
   logic [ADDR_WIDTH-1:0] o_rom_addr;
   logic [DATA_WIDTH-1:0] i_rom_data;
   logic                  o_busy;

   modport slave (
      input  i_req0, i_req1, i_addr0, i_addr1, i_rom_data,
      output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
             o_err0, o_err1, o_rom_addr, o_busy
   );

   modport master (
      output i_req0, i_req1, i_addr0, i_addr1, i_rom_data,
      input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
             o_err0, o_err1, o_rom_addr, o_busy
   );
endinterface

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
// Shares the single-ported instruction ROM between the fetch requester
// (port 0) and the data requester (port 1). Each access is a two-cycle slot:
// grant/latch in IDLE, ROM read in ACCESS, response pulse on the following
// cycle. Byte addresses become word indices; misaligned or out-of-range
// accesses return ERR_DATA with the error flag set.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      rom_port_arbiter_if.slave (requests, grants, responses, ROM path)
// Build option:
//   ROM_ARB_RR_EN  defined -> round-robin arbitration between the two ports;
//                  undefined -> fixed priority, port 0 always wins.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | grants offered to one winner; winner latched on the edge
// ACCESS | grants low; ROM word (or ERR_DATA) captured for latched port
module rom_port_arbiter #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ROM_WORDS  = 1024,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA   = {DATA_WIDTH{1'b0}}
) (
   input logic                i_clk,
   input logic                i_rst_n,
   rom_port_arbiter_if.slave  bus
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ROM_LIMIT = ADDR_WIDTH'(ROM_WORDS);

   state_t                state;
   logic                  sel_id;
   logic                  err_lat;
   logic                  any_req;
   logic                  win_id;
   logic                  grant_en;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [ADDR_WIDTH-1:0] win_index;
   logic                  win_err;

   assign any_req = bus.i_req0 | bus.i_req1;

`ifdef ROM_ARB_RR_EN
   // Pointer names the preferred port; only consulted when both request.
   logic prio_ptr;
   assign win_id = (bus.i_req0 & bus.i_req1) ? prio_ptr : bus.i_req1;
`else
   assign win_id = bus.i_req1 & ~bus.i_req0;
`endif

   // Grants are gated by reset so nothing is accepted while held in reset.
   assign grant_en   = (state == S_IDLE) & any_req & i_rst_n;
   assign bus.o_gnt0 = grant_en & ~win_id;
   assign bus.o_gnt1 = grant_en & win_id;

   assign win_addr  = win_id ? bus.i_addr1 : bus.i_addr0;
   assign win_index = {2'b00, win_addr[ADDR_WIDTH-1:2]};
   assign win_err   = (win_addr[1:0] != 2'b00) | (win_index >= ROM_LIMIT);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= S_IDLE;
         sel_id         <= 1'b0;
         err_lat        <= 1'b0;
         bus.o_rom_addr <= '0;
         bus.o_busy     <= 1'b0;
         bus.o_rvalid0  <= 1'b0;
         bus.o_rvalid1  <= 1'b0;
         bus.o_err0     <= 1'b0;
         bus.o_err1     <= 1'b0;
         bus.o_rdata0   <= '0;
         bus.o_rdata1   <= '0;
`ifdef ROM_ARB_RR_EN
         prio_ptr       <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               // Response flags are single-cycle pulses.
               bus.o_rvalid0 <= 1'b0;
               bus.o_rvalid1 <= 1'b0;
               bus.o_err0    <= 1'b0;
               bus.o_err1    <= 1'b0;
               if (any_req) begin
                  sel_id         <= win_id;
                  err_lat        <= win_err;
                  bus.o_rom_addr <= win_index;
                  bus.o_busy     <= 1'b1;
                  state          <= S_ACCESS;
`ifdef ROM_ARB_RR_EN
                  prio_ptr       <= ~win_id;
`endif
               end
            end
            S_ACCESS: begin
               if (sel_id) begin
                  bus.o_rdata1  <= err_lat ? ERR_DATA : bus.i_rom_data;
                  bus.o_err1    <= err_lat;
                  bus.o_rvalid1 <= 1'b1;
               end else begin
                  bus.o_rdata0  <= err_lat ? ERR_DATA : bus.i_rom_data;
                  bus.o_err0    <= err_lat;
                  bus.o_rvalid0 <= 1'b1;
               end
               bus.o_busy <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Two-port arbiter and access sequencer for the single-ported instruction ROM of the MIPS core. It shares one ROM read path between an instruction-fetch requester (port 0) and a data/load requester (port 1). It converts byte addresses to word indices and flags misaligned or out-of-range accesses. Each access runs as a registered two-phase transaction with a req/gnt request handshake and a one-cycle rvalid response pulse.

## Interface
- ADDR_WIDTH, 32, width of requester byte addresses and of the ROM index bus
- DATA_WIDTH, 32, ROM word width
- ROM_WORDS, 1024, number of valid ROM words; a word index ≥ ROM_WORDS is out of range
- ERR_DATA, {DATA_WIDTH{1'b0}}, value returned on o_rdataN for an erroneous access

- i_clk  input  1  clock; rising edge active
- i_rst_n  input  1  asynchronous, active-low reset
- i_req0 / i_req1  input  1  access request, port 0 (fetch) / port 1 (data)
- i_addr0 / i_addr1  input  ADDR_WIDTH  byte address; held stable while reqN=1 and gntN=0
- o_gnt0 / o_gnt1  output  1  combinational grant; the request is accepted on an edge where reqN&gntN=1
- o_rvalidN  output  1  one-cycle pulse; o_rdataN and o_errN are valid in that cycle
- o_rdataN  output  DATA_WIDTH  read data, registered, held until the next response on that port
- o_errN  output  1  misaligned or out-of-range access, registered with o_rvalidN
- o_rom_addr  output  ADDR_WIDTH  word index driven to ROM, registered
- i_rom_data  input  DATA_WIDTH  combinational ROM output for o_rom_addr
- o_busy  output  1  high while in ACCESS

## Operation
- FSM states: IDLE and ACCESS. The reset state is IDLE.
- IDLE:
  - If any reqN is high, the arbiter asserts o_gnt for exactly one winner.
  - On the edge, it latches the winner's id, word index addr[ADDR_WIDTH-1:2] into o_rom_addr, and the error condition.
  - It then moves to ACCESS.
  - With no request, it stays in IDLE with both grants low.
- ACCESS:
  - Grants are forced low.
  - On the edge, i_rom_data (or ERR_DATA if the latched error is set) is registered into o_rdata of the latched port.
  - o_err and o_rvalid of that port are set for one cycle, and the FSM returns to IDLE.
- Error condition: addr[1:0]≠0 OR word index ≥ ROM_WORDS. An erroneous access still takes the full two-cycle slot.
- o_rvalid of the other port stays 0. o_rdata of the other port holds its last value.
- A requester may drop reqN before grant without side effects.
- Simultaneous reqs are resolved by the arbitration policy (see Configuration).
- Reset values: state=IDLE, o_gnt0/1=0 (gated by i_rst_n), o_rvalid0/1=0, o_err0/1=0, o_rdata0/1=0, o_rom_addr=0, o_busy=0, priority pointer=port 0.

## Timing
- Accept at edge k → ROM addressed during cycle k..k+1 → o_rvalidN high in the cycle after edge k+1. Latency: 2 edges from acceptance.
- Peak throughput: one access per 2 cycles. A new grant may occur in the same IDLE cycle in which the previous o_rvalid is high.
- Asserting reset mid-ACCESS aborts the access: no rvalid is issued and all outputs go to their reset values immediately.
- o_rom_addr changes only on the IDLE→ACCESS edge. It is stable for the whole ACCESS cycle.

## Configuration
- ROM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port.
  - After each grant, the pointer moves to the non-granted port.
  - With both ports requesting continuously, grants alternate 0,1,0,1.
- ROM_ARB_RR_EN undefined: fixed priority, port 0 always wins. No pointer register exists.

## Test plan
- Single fetch: req0, addr0=0x0000_0008, ROM word 2=0x2008_0005 → gnt0 in the request cycle, o_rvalid0 2 edges later with o_rdata0=0x2008_0005, o_err0=0, o_rvalid1 stays 0.
- Contention: req0 and req1 both held high for 8 cycles → with ROM_ARB_RR_EN, grant order is 0,1,0,1. Without it, grant order is 0,0,0,0 and port 1 is starved. One rvalid occurs per 2 cycles.
- Misaligned: addr1=0x0000_0006 → o_rvalid1 with o_err1=1 and o_rdata1=ERR_DATA. The next aligned access then succeeds.
- Out of range: addr0=ROM_WORDS*4 (0x1000) → o_err0=1, rdata=ERR_DATA. addr0=0x0FFC → o_err0=0 and returns word 1023.
- Reset mid-ACCESS: drop i_rst_n during ACCESS → no rvalid, o_busy=0 and o_rom_addr=0 immediately. After release, a new request completes normally.
- Request withdrawn: req1 raised while port 0 is in ACCESS, then dropped before IDLE → no gnt1 and no rvalid1.
